// File: rtl/loss_detector.sv
// rtl/loss_detector.sv - bird/pipe collision supervisor with IDLE/PLAY/LOST sequencing and pipe score
// Optional build macro SCORE_BCD_EN: score counts as two BCD digits, saturating at 8'h99.
module loss_detector #(
    parameter int ROWS        = 8,
    parameter int SCORE_W     = 8,
    parameter int GRACE_TICKS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [ROWS-1:0]    birdRow,
    input  logic [ROWS-1:0]    pipeRow,
    output logic               lossDetect,
    output logic               playing,
    output logic [SCORE_W-1:0] score
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] LOST = 2'd2;

    localparam int GRACE_W = (GRACE_TICKS < 2) ? 1 : $clog2(GRACE_TICKS + 1);
    localparam logic [GRACE_W-1:0] GRACE_INIT = GRACE_W'(GRACE_TICKS);

    logic [1:0]         state;
    logic [GRACE_W-1:0] grace;
    logic               pipe_prev;
    logic               start_prev;
    logic [SCORE_W-1:0] score_inc;

    logic start_rise;
    logic hit;
    logic pipe_now;
    logic pipe_passed;

    assign start_rise  = start & ~start_prev;
    assign hit         = (|(birdRow & pipeRow)) | (birdRow == '0);
    assign pipe_now    = |pipeRow;
    assign pipe_passed = pipe_prev & ~pipe_now;

    // Outputs decode the state directly so an asynchronous reset drops them at once.
    assign lossDetect = (state == LOST);
    assign playing    = (state == PLAY);

`ifdef SCORE_BCD_EN
    always_comb begin
        score_inc = score;
        if (score[7:0] != 8'h99) begin
            if (score[3:0] == 4'd9) begin
                score_inc[3:0] = 4'd0;
                score_inc[7:4] = score[7:4] + 4'd1;
            end else begin
                score_inc[3:0] = score[3:0] + 4'd1;
            end
        end
    end
`else
    always_comb begin
        score_inc = score;
        if (score != '1) begin
            score_inc = score + SCORE_W'(1);
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= start;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            score     <= '0;
            grace     <= '0;
            pipe_prev <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state     <= PLAY;
                        score     <= '0;
                        grace     <= GRACE_INIT;
                        pipe_prev <= 1'b0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        pipe_prev <= pipe_now;
                        // During grace the hit is ignored but pipes still score.
                        if (grace != '0) begin
                            grace <= grace - GRACE_W'(1);
                            if (pipe_passed) begin
                                score <= score_inc;
                            end
                        end else if (hit) begin
                            state <= LOST;
                        end else if (pipe_passed) begin
                            score <= score_inc;
                        end
                    end
                end
                LOST: begin
                    if (start_rise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loss_detector.sv
// tb/tb_loss_detector.sv - table-driven and sequence checks for loss_detector
module tb_loss_detector;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       start;
    logic [7:0] birdRow;
    logic [7:0] pipeRow;
    logic       lossDetect;
    logic       playing;
    logic [7:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    loss_detector #(.ROWS(8), .SCORE_W(8), .GRACE_TICKS(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .birdRow    (birdRow),
        .pipeRow    (pipeRow),
        .lossDetect (lossDetect),
        .playing    (playing),
        .score      (score)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       tick;
        logic       start;
        logic [7:0] bird;
        logic [7:0] pipe;
        logic       exp_loss;
        logic       exp_play;
        logic [7:0] exp_score;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic [7:0] b, input logic [7:0] p);
        tick    = t;
        start   = s;
        birdRow = b;
        pipeRow = p;
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string name, input logic l, input logic pl, input logic [7:0] sc);
        check({name, ".loss"},  {31'd0, lossDetect}, {31'd0, l});
        check({name, ".play"},  {31'd0, playing},    {31'd0, pl});
        check({name, ".score"}, {24'd0, score},      {24'd0, sc});
    endtask

    function automatic logic [7:0] exp_score(input int n);
`ifdef SCORE_BCD_EN
        if (n >= 99) return 8'h99;
        return 8'((n / 10) * 16 + (n % 10));
`else
        if (n >= 255) return 8'hFF;
        return 8'(n);
`endif
    endfunction

    initial begin
        int n_pass;
`ifdef SCORE_BCD_EN
        n_pass = 100;
`else
        n_pass = 256;
`endif
        //               tick  start bird   pipe   loss  play  score
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h08, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h08, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h08, 1'b1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 1'b0, 8'h08, 8'h08, 1'b1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'h00, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'h00, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'hF0, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'h00, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'hF0, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01});

        reset   = 1'b1;
        tick    = 1'b0;
        start   = 1'b0;
        birdRow = 8'h00;
        pipeRow = 8'h00;
        #12;
        check_outs("reset", 1'b0, 1'b0, 8'h00);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].tick, vecs[i].start, vecs[i].bird, vecs[i].pipe);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_loss, vecs[i].exp_play, vecs[i].exp_score);
        end

        // Saturation: new game, burn grace, then clear more pipes than the score can hold.
        step(1'b0, 1'b0, 8'h04, 8'h00);
        step(1'b0, 1'b1, 8'h04, 8'h00);
        check_outs("sat.start", 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h04, 8'h00);
        step(1'b1, 1'b1, 8'h04, 8'h00);
        for (int i = 1; i <= n_pass; i++) begin
            step(1'b1, 1'b1, 8'h04, 8'hF0);
            step(1'b1, 1'b1, 8'h04, 8'h00);
            if (i == 1 || i == 9 || i == 10 || i == n_pass - 1 || i == n_pass) begin
                check_outs($sformatf("sat.pass%0d", i), 1'b0, 1'b1, exp_score(i));
            end
        end

        // Asynchronous reset mid-PLAY, checked before the next clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_outs("rst.play", 1'b0, 1'b0, 8'h00);
        #2;
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h00, 8'h00);
        check_outs("rst.idle", 1'b0, 1'b0, 8'h00);

        // Asynchronous reset while LOST.
        step(1'b0, 1'b1, 8'h04, 8'h00);
        step(1'b1, 1'b1, 8'h04, 8'h00);
        step(1'b1, 1'b1, 8'h04, 8'h00);
        step(1'b1, 1'b1, 8'h00, 8'h00);
        check_outs("lost.again", 1'b1, 1'b0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check_outs("rst.lost", 1'b0, 1'b0, 8'h00);
        #2;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
